// File: rtl/key_pkg.sv
// ----------------------------------------------------------------------------
// key_pkg
// Shared definitions for the key/switch command front end.
//   - key_state_t : FSM state encoding (IDLE, DEBOUNCE, VALID, RELEASE)
//   - KEY_W       : default width of the raw key bus and of InputKey
//   - DEBOUNCE_CYCLES_DEF / REPEAT_CYCLES_DEF : default timing constants
// Related build macro: KEY_REPEAT_EN (used by key_cmd_capture).
// ----------------------------------------------------------------------------
package key_pkg;

    localparam int KEY_W               = 5;
    localparam int DEBOUNCE_CYCLES_DEF = 4;
    localparam int REPEAT_CYCLES_DEF   = 16;

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        DEBOUNCE = 2'd1,
        VALID    = 2'd2,
        RELEASE  = 2'd3
    } key_state_t;

endpackage : key_pkg

// File: rtl/key_sync2.sv
// ----------------------------------------------------------------------------
// key_sync2
// Bitwise two-flop synchroniser for an asynchronous level bus.
// Both stages clear on the synchronous active-high reset.
// Ports:
//   Clk    in   system clock, rising edge
//   Reset  in   synchronous active-high reset
//   i_d    in   [W-1:0] asynchronous input levels
//   o_q    out  [W-1:0] synchronised levels (stage-2 output)
// ----------------------------------------------------------------------------
module key_sync2 #(
    parameter int W = 5
) (
    input  logic         Clk,
    input  logic         Reset,
    input  logic [W-1:0] i_d,
    output logic [W-1:0] o_q
);

    logic [W-1:0] r_meta;
    logic [W-1:0] r_sync;

    always_ff @(posedge Clk) begin
        if (Reset) begin
            r_meta <= '0;
            r_sync <= '0;
        end else begin
            r_meta <= i_d;
            r_sync <= r_meta;
        end
    end

    assign o_q = r_sync;

endmodule : key_sync2

// File: rtl/key_cmd_capture.sv
// ----------------------------------------------------------------------------
// key_cmd_capture
// Front end for the Controller FSM: synchronises and debounces a raw key bus,
// issues one command per press (InputKey + level ValidCmd) and demands a
// clean, debounced release before another command can be accepted.
//
// Ports:
//   Clk          in   system clock, rising edge
//   Reset        in   synchronous active-high reset
//   RawKey       in   [KEY_W-1:0] asynchronous raw key levels, 0 = no key
//   InputKey     out  [KEY_W-1:0] qualified key code for the Controller
//   ValidCmd     out  high while InputKey holds an accepted command
//   Busy         out  high while in DEBOUNCE or RELEASE
//   o_dbg_state  out  [1:0] current FSM state (key_state_t encoding)
//
// Build option: define KEY_REPEAT_EN to enable auto-repeat while a key is
// held (ValidCmd drops for one cycle every REPEAT_CYCLES cycles in VALID).
// ----------------------------------------------------------------------------
module key_cmd_capture
    import key_pkg::*;
#(
    parameter int KEY_W           = key_pkg::KEY_W,
    parameter int DEBOUNCE_CYCLES = key_pkg::DEBOUNCE_CYCLES_DEF,
    parameter int REPEAT_CYCLES   = key_pkg::REPEAT_CYCLES_DEF
) (
    input  logic             Clk,
    input  logic             Reset,
    input  logic [KEY_W-1:0] RawKey,
    output logic [KEY_W-1:0] InputKey,
    output logic             ValidCmd,
    output logic             Busy,
    output logic [1:0]       o_dbg_state
);

    // Elaboration-time guard on the legal parameter ranges.
    if (DEBOUNCE_CYCLES < 1 || REPEAT_CYCLES < 2) begin : g_param_check
        $error("key_cmd_capture: DEBOUNCE_CYCLES must be >=1 and REPEAT_CYCLES >=2");
    end

    // The counter is compared against DEBOUNCE_CYCLES-1 before incrementing,
    // so it never needs to hold more than DEBOUNCE_CYCLES-1.
    localparam int CNT_W = $clog2(DEBOUNCE_CYCLES + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

    // ------------------------------------------------------------------
    // Synchroniser
    // ------------------------------------------------------------------
    logic [KEY_W-1:0] w_sync_key;

    key_sync2 #(
        .W (KEY_W)
    ) u_sync (
        .Clk   (Clk),
        .Reset (Reset),
        .i_d   (RawKey),
        .o_q   (w_sync_key)
    );

    // ------------------------------------------------------------------
    // State and output registers
    // ------------------------------------------------------------------
    key_state_t       r_state,  w_state_nxt;
    logic [CNT_W-1:0] r_cnt,    w_cnt_nxt;
    logic [KEY_W-1:0] r_cand,   w_cand_nxt;
    logic [KEY_W-1:0] r_key,    w_key_nxt;
    logic             r_valid,  w_valid_nxt;
    logic             r_busy,   w_busy_nxt;

`ifdef KEY_REPEAT_EN
    localparam int RPT_W = $clog2(REPEAT_CYCLES);
    localparam logic [RPT_W-1:0] RPT_LAST = RPT_W'(REPEAT_CYCLES - 1);
    logic [RPT_W-1:0] r_rpt_cnt, w_rpt_cnt_nxt;
`endif

    always_ff @(posedge Clk) begin
        if (Reset) begin
            r_state <= IDLE;
            r_cnt   <= '0;
            r_cand  <= '0;
            r_key   <= '0;
            r_valid <= 1'b0;
            r_busy  <= 1'b0;
`ifdef KEY_REPEAT_EN
            r_rpt_cnt <= '0;
`endif
        end else begin
            r_state <= w_state_nxt;
            r_cnt   <= w_cnt_nxt;
            r_cand  <= w_cand_nxt;
            r_key   <= w_key_nxt;
            r_valid <= w_valid_nxt;
            r_busy  <= w_busy_nxt;
`ifdef KEY_REPEAT_EN
            r_rpt_cnt <= w_rpt_cnt_nxt;
`endif
        end
    end

    // ------------------------------------------------------------------
    // Next-state / next-output logic
    // ------------------------------------------------------------------
    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        w_cand_nxt  = r_cand;
        w_key_nxt   = r_key;
        w_valid_nxt = r_valid;
`ifdef KEY_REPEAT_EN
        w_rpt_cnt_nxt = r_rpt_cnt;
`endif

        unique case (r_state)
            IDLE: begin
                w_key_nxt   = '0;
                w_valid_nxt = 1'b0;
                if (w_sync_key != '0) begin
                    w_state_nxt = DEBOUNCE;
                    w_cand_nxt  = w_sync_key;
                    w_cnt_nxt   = '0;
                end
            end

            DEBOUNCE: begin
                if (w_sync_key == '0) begin
                    w_state_nxt = IDLE;
                end else if (w_sync_key != r_cand) begin
                    // A chord or code change restarts qualification.
                    w_cand_nxt = w_sync_key;
                    w_cnt_nxt  = '0;
                end else if (r_cnt == CNT_LAST) begin
                    w_state_nxt = VALID;
                    w_key_nxt   = r_cand;
                    w_valid_nxt = 1'b1;
`ifdef KEY_REPEAT_EN
                    w_rpt_cnt_nxt = '0;
`endif
                end else begin
                    w_cnt_nxt = r_cnt + 1'b1;
                end
            end

            VALID: begin
                // Release or a different code both end the command; the
                // check comes first so it also wins during a repeat gap.
                if (w_sync_key != r_key) begin
                    w_state_nxt = RELEASE;
                    w_valid_nxt = 1'b0;
                    w_cnt_nxt   = '0;
                end else begin
`ifdef KEY_REPEAT_EN
                    if (r_rpt_cnt == RPT_LAST) begin
                        w_valid_nxt   = 1'b0;
                        w_rpt_cnt_nxt = '0;
                    end else begin
                        w_valid_nxt   = 1'b1;
                        w_rpt_cnt_nxt = r_rpt_cnt + 1'b1;
                    end
`else
                    w_valid_nxt = 1'b1;
`endif
                end
            end

            RELEASE: begin
                // InputKey keeps its last value until the release is clean.
                w_valid_nxt = 1'b0;
                if (w_sync_key != '0) begin
                    w_cnt_nxt = '0;
                end else if (r_cnt == CNT_LAST) begin
                    w_state_nxt = IDLE;
                    w_key_nxt   = '0;
                end else begin
                    w_cnt_nxt = r_cnt + 1'b1;
                end
            end

            default: begin
                w_state_nxt = IDLE;
            end
        endcase

        // Registered from the next state so Busy lines up with the state.
        w_busy_nxt = (w_state_nxt == DEBOUNCE) || (w_state_nxt == RELEASE);
    end

    assign InputKey    = r_key;
    assign ValidCmd    = r_valid;
    assign Busy        = r_busy;
    assign o_dbg_state = r_state;

endmodule : key_cmd_capture

// File: tb/tb_key_cmd_capture.sv
// ----------------------------------------------------------------------------
// tb_key_cmd_capture
// Directed scenarios followed by random key segments. A run-length model of
// the command rules predicts InputKey, ValidCmd, Busy and state every cycle;
// selected points are additionally checked against fixed timing constants.
// ----------------------------------------------------------------------------
module tb_key_cmd_capture;

  localparam int D   = 4;
  localparam int REP = 8;

  // ---------------- clock / reset ----------------
  logic       Clk = 1'b0;
  logic       Reset;
  logic [4:0] RawKey;
  logic [4:0] InputKey;
  logic       ValidCmd;
  logic       Busy;
  logic [1:0] o_dbg_state;

  always #5 Clk = ~Clk;

  key_cmd_capture #(
    .KEY_W           (5),
    .DEBOUNCE_CYCLES (D),
    .REPEAT_CYCLES   (REP)
  ) dut (
    .Clk         (Clk),
    .Reset       (Reset),
    .RawKey      (RawKey),
    .InputKey    (InputKey),
    .ValidCmd    (ValidCmd),
    .Busy        (Busy),
    .o_dbg_state (o_dbg_state)
  );

  // ---------------- bookkeeping ----------------
  int checks = 0;
  int errors = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, got, exp);
    end
  endtask

  // ---------------- reference model ----------------
  // Modes: ready (waiting for a run of D+1 identical nonzero synced samples),
  // issued (command held), releasing (waiting for D zero samples in a row).
  localparam int M_READY = 0, M_ISSUED = 1, M_REL = 2;
  logic [4:0] m_p1, m_p2;
  int         m_mode;
  int         m_run;
  logic [4:0] m_run_val;
  int         m_zrun;
  logic [4:0] m_key;
  logic       m_vld;
  int         m_rp;

  task automatic model_reset();
    m_p1 = '0; m_p2 = '0; m_mode = M_READY; m_run = 0; m_run_val = '0;
    m_zrun = 0; m_key = '0; m_vld = 1'b0; m_rp = 0;
  endtask

  task automatic model_edge(input logic [4:0] raw, input logic rst);
    logic [4:0] s;
    if (rst) begin
      model_reset();
      return;
    end
    s    = m_p2;
    m_p2 = m_p1;
    m_p1 = raw;
    case (m_mode)
      M_READY: begin
        if (s == 0) m_run = 0;
        else if (m_run > 0 && s == m_run_val) m_run++;
        else begin m_run_val = s; m_run = 1; end
        if (m_run == D + 1) begin
          m_mode = M_ISSUED; m_key = m_run_val; m_vld = 1'b1; m_rp = 0; m_run = 0;
        end
      end
      M_ISSUED: begin
        if (s != m_key) begin
          m_mode = M_REL; m_zrun = 0; m_vld = 1'b0;
        end else begin
`ifdef KEY_REPEAT_EN
          if (m_rp == REP - 1) begin m_vld = 1'b0; m_rp = 0; end
          else begin m_vld = 1'b1; m_rp++; end
`else
          m_vld = 1'b1;
`endif
        end
      end
      default: begin
        if (s != 0) m_zrun = 0;
        else begin
          m_zrun++;
          if (m_zrun == D) begin m_mode = M_READY; m_key = '0; m_run = 0; end
        end
      end
    endcase
  endtask

  function automatic logic [1:0] model_state();
    if (m_mode == M_ISSUED) return 2'd2;
    if (m_mode == M_REL)    return 2'd3;
    return (m_run > 0) ? 2'd1 : 2'd0;
  endfunction

  // ---------------- driver ----------------
  task automatic tick(input logic [4:0] raw, input logic rst);
    RawKey = raw;
    Reset  = rst;
    @(posedge Clk);
    model_edge(raw, rst);
    #1;
    chk("m_valid", {31'd0, ValidCmd}, {31'd0, m_vld});
    chk("m_key",   {27'd0, InputKey}, {27'd0, m_key});
    chk("m_state", {30'd0, o_dbg_state}, {30'd0, model_state()});
    chk("m_busy",  {31'd0, Busy}, {31'd0, (model_state() == 2'd1) || (model_state() == 2'd3)});
    @(negedge Clk);
  endtask

  // ---------------- stimulus ----------------
  int lows;
  logic [4:0] seg_val;
  int seg_len;

  initial begin
    Reset  = 1'b1;
    RawKey = '0;
    model_reset();
    @(negedge Clk);

    // Reset for two cycles with no key.
    tick(5'b0, 1'b1);
    tick(5'b0, 1'b1);
    chk("rst_valid", {31'd0, ValidCmd}, 32'd0);
    chk("rst_key",   {27'd0, InputKey}, 32'd0);
    chk("rst_busy",  {31'd0, Busy}, 32'd0);

    // Clean press: ValidCmd rises on edge D+3 = 7.
    for (int i = 1; i <= 7; i++) begin
      tick(5'b10101, 1'b0);
      chk("press_valid", {31'd0, ValidCmd}, {31'd0, (i >= 7)});
    end
    chk("press_key", {27'd0, InputKey}, 32'h15);
    for (int i = 0; i < 4; i++) tick(5'b10101, 1'b0);
    // Release: ValidCmd low on edge 3, InputKey cleared on edge 7.
    for (int i = 1; i <= 8; i++) begin
      tick(5'b0, 1'b0);
      if (i == 2) chk("rel_valid_e2", {31'd0, ValidCmd}, 32'd1);
      if (i == 3) chk("rel_valid_e3", {31'd0, ValidCmd}, 32'd0);
      if (i == 6) chk("rel_key_e6", {27'd0, InputKey}, 32'h15);
      if (i == 7) chk("rel_key_e7", {27'd0, InputKey}, 32'h0);
    end

    // Bounce: 00001/00000 every 2 cycles for 12 cycles, then hold.
    for (int i = 0; i < 12; i++) begin
      tick(((i / 2) % 2 == 0) ? 5'b00001 : 5'b00000, 1'b0);
      chk("bounce_valid", {31'd0, ValidCmd}, 32'd0);
    end
    for (int i = 1; i <= 7; i++) begin
      tick(5'b00001, 1'b0);
      chk("bounce_hold_valid", {31'd0, ValidCmd}, {31'd0, (i >= 7)});
    end

    // Code change while held: no 00101 command without a clean release.
    for (int i = 0; i < 12; i++) tick(5'b00101, 1'b0);
    chk("chg_valid", {31'd0, ValidCmd}, 32'd0);
    chk("chg_key",   {27'd0, InputKey}, 32'h01);
    for (int i = 0; i < 8; i++) tick(5'b0, 1'b0);
    for (int i = 0; i < 8; i++) tick(5'b00101, 1'b0);
    chk("chg2_valid", {31'd0, ValidCmd}, 32'd1);
    chk("chg2_key",   {27'd0, InputKey}, 32'h05);
    for (int i = 0; i < 10; i++) tick(5'b0, 1'b0);

    // Chord during debounce: count restarts on 10000.
    tick(5'b00001, 1'b0);
    tick(5'b00001, 1'b0);
    for (int i = 1; i <= 7; i++) begin
      tick(5'b10000, 1'b0);
      chk("chord_valid", {31'd0, ValidCmd}, {31'd0, (i >= 7)});
    end
    chk("chord_key", {27'd0, InputKey}, 32'h10);

    // Reset while VALID, key still held.
    tick(5'b10000, 1'b1);
    chk("rstv_valid", {31'd0, ValidCmd}, 32'd0);
    chk("rstv_key",   {27'd0, InputKey}, 32'd0);
    for (int i = 1; i <= 7; i++) begin
      tick(5'b10000, 1'b0);
      chk("rstv_requal", {31'd0, ValidCmd}, {31'd0, (i >= 7)});
    end

    // Held key for 30 cycles in VALID: count ValidCmd low cycles.
    lows = 0;
    for (int i = 0; i < 30; i++) begin
      tick(5'b10000, 1'b0);
      if (!ValidCmd) lows++;
      chk("hold_key", {27'd0, InputKey}, 32'h10);
    end
`ifdef KEY_REPEAT_EN
    chk("hold_lows", lows, 32'd3);
`else
    chk("hold_lows", lows, 32'd0);
`endif
    for (int i = 0; i < 10; i++) tick(5'b0, 1'b0);

    // Random segments: quiet, stable keys, short bounces, occasional reset.
    for (int seg = 0; seg < 80; seg++) begin
      case ($urandom_range(0, 5))
        0, 1: seg_val = 5'b0;
        2:    seg_val = 5'($urandom_range(1, 3));
        default: seg_val = 5'($urandom_range(1, 31));
      endcase
      seg_len = $urandom_range(1, 14);
      for (int i = 0; i < seg_len; i++) begin
        if ($urandom_range(0, 9) == 0)
          tick(seg_val ^ 5'($urandom_range(0, 31)), 1'b0);
        else
          tick(seg_val, ($urandom_range(0, 199) == 0));
      end
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule : tb_key_cmd_capture

// File: doc/key_cmd_capture.md
Name: key_cmd_capture

Overview:
- Upstream front end for the Controller FSM.
- Turns a raw, asynchronous, bouncing 5-bit key/switch bus into a clean `InputKey[4:0]` plus a level `ValidCmd`, which are exactly the Controller's command inputs.
- Work done: synchronises the raw bus, debounces it, qualifies one command per press, and enforces a clean release before the next command is accepted.
- Sits between the board push-buttons/switches and the Controller, on the same `Clk`/`Reset`.

Parameters:
- KEY_W, 5, width of raw key bus and of `InputKey`.
- DEBOUNCE_CYCLES, 4, consecutive stable synchronised cycles required to accept a press or a release. Legal range ≥1.
- REPEAT_CYCLES, 16, auto-repeat period in cycles. Used only with `KEY_REPEAT_EN`. Legal range ≥2.

Ports:
- Clk  input  1  system clock, rising edge.
- Reset  input  1  synchronous, active-high reset.
- RawKey  input  KEY_W  asynchronous raw key levels; all-zero means no key.
- InputKey  output  KEY_W  qualified key code; feeds `Controller.InputKey`.
- ValidCmd  output  1  high while `InputKey` holds an accepted command; feeds `Controller.ValidCmd`.
- Busy  output  1  high in DEBOUNCE or RELEASE (status/LED use).

Behaviour:
- One clock; reset is synchronous and active-high.
- Reset: on any edge with `Reset`=1:
  - state→IDLE.
  - Both synchroniser stages, `InputKey`, `ValidCmd`, `Busy` and all counters → 0.
  - Reset overrides every other transition, including mid-debounce and mid-VALID.
- Synchroniser: 2-flop, bitwise. `sync_key` = stage-2 output. All FSM decisions use `sync_key` only.
- FSM states (2-bit encoding): IDLE, DEBOUNCE, VALID, RELEASE.
- IDLE:
  - Outputs: `InputKey`=0, `ValidCmd`=0.
  - If `sync_key`≠0: go to DEBOUNCE, load `cand`←`sync_key`, `cnt`←0.
- DEBOUNCE:
  - If `sync_key`==0: go to IDLE.
  - Else if `sync_key`≠`cand`: stay, reload `cand`←`sync_key`, `cnt`←0. A chord or code change restarts the count.
  - Else if `cnt`==DEBOUNCE_CYCLES-1: go to VALID, `InputKey`←`cand`, `ValidCmd`←1.
  - Else `cnt`++.
- VALID:
  - `ValidCmd`=1; `InputKey` is held constant.
  - If `sync_key`≠`InputKey` (release or a different code): go to RELEASE, `ValidCmd`←0, `cnt`←0.
- RELEASE:
  - `ValidCmd`=0; `InputKey` holds its last value.
  - If `sync_key`≠0: `cnt`←0 and stay.
  - Else if `cnt`==DEBOUNCE_CYCLES-1: go to IDLE, `InputKey`←0.
  - Else `cnt`++.
  - A new code pressed without an intervening clean release is never issued.
- Latency: counting the first edge that samples a new stable `RawKey` as edge 1, `ValidCmd` rises on edge DEBOUNCE_CYCLES+3. With D=4 that is edge 7.
- `Busy` = registered (state==DEBOUNCE || state==RELEASE).
- `cnt` width: $clog2(DEBOUNCE_CYCLES+1). It never wraps, because it is compared before incrementing.

Optional Feature:
- Macro: `KEY_REPEAT_EN`.
- Defined:
  - In VALID, `rpt_cnt` increments every cycle.
  - On `rpt_cnt`==REPEAT_CYCLES-1: `ValidCmd` drops for exactly one cycle, then re-asserts with the same `InputKey`, and `rpt_cnt`←0.
  - This gives the Controller a fresh command edge while the key is held.
  - A release detected during the low cycle still goes to RELEASE.
  - `rpt_cnt` clears on entry to VALID and on reset.
- Undefined: `ValidCmd` is a steady level for the whole of VALID. No `rpt_cnt` logic is generated.

Decomposition:
- Shared package `key_pkg` holds:
  - state typedef {IDLE=2'd0, DEBOUNCE=2'd1, VALID=2'd2, RELEASE=2'd3}.
  - `KEY_W`.
  - Default debounce/repeat constants.
- One natural sub-module, `key_sync2`: parameterised-width 2-flop synchroniser with synchronous reset.
- FSM, counters and output registers stay in `key_cmd_capture`.

Test Plan:
- Run all scenarios with DEBOUNCE_CYCLES=4 and RawKey held at 0 during Reset.
- Clean press: `Reset` 1 for 2 cycles, then `RawKey`=10101 held → `ValidCmd`=1 and `InputKey`=10101 on edge 7. Release to 00000 → `ValidCmd`=0 3 edges after release; `InputKey`=0 and state IDLE 4 cycles later.
- Bounce: `RawKey` alternates 00001/00000 every 2 cycles for 12 cycles, then holds 00001 → `ValidCmd` stays 0 throughout the bounce and rises on edge 7 after the stable hold begins.
- Code change while held: accepted 00001, then `RawKey` switches directly to 00101 → `ValidCmd` drops; no 00101 command is issued. Set `RawKey` to 0 for ≥4 synced cycles, then 00101 → `ValidCmd`=1 with `InputKey`=00101.
- Chord during debounce: 00001 for 2 synced cycles then 10000 → count restarts; `ValidCmd` rises 4 synced cycles after 10000 is stable, with `InputKey`=10000.
- Reset mid-VALID: while `ValidCmd`=1 assert `Reset` for 1 cycle with the key still held → next edge `ValidCmd`=0 and `InputKey`=0; the same key re-qualifies on edge 7 after `Reset` drops.
- `KEY_REPEAT_EN`, REPEAT_CYCLES=8, key held 30 cycles in VALID → `ValidCmd` low for exactly 1 cycle every 8 cycles and `InputKey` constant; without the macro → `ValidCmd` stays high for all 30 cycles.
